// File: rtl/frame_dump_if.sv
// Bus bundle between the frame dump sequencer and its environment:
// control pulses, buffer read port, UART byte port and status.
interface frame_dump_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic          start;
  logic          abort;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [31:0]   rd_data;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic          uart_busy;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  // Byte handshake: tx_wr is a one-cycle strobe with tx_data valid in that
  // cycle; the UART signals back-pressure only through uart_busy, and the
  // sequencer never strobes unless uart_busy has been low for the holdoff.
  modport master (
    input  start, abort, rd_data, uart_busy,
    output rd_x, rd_y, tx_wr, tx_data, busy, done, dbg_state
  );

  modport slave (
    output start, abort, rd_data, uart_busy,
    input  rd_x, rd_y, tx_wr, tx_data, busy, done, dbg_state
  );
endinterface

// File: rtl/frame_dump_seq.sv
// Walks a COLS x ROWS word buffer and serialises each word as bytes to a
// UART, optionally preceded by a sync header byte, with a quiet-line holdoff.
module frame_dump_seq #(
  parameter int         COLS           = 40,
  parameter int         ROWS           = 30,
  parameter int         BYTES_PER_WORD = 4,
  parameter int         MSB_FIRST      = 1,
  parameter int         HOLDOFF        = 8191,
  parameter int         READ_LAT       = 1,
  parameter int         HEADER_EN      = 1,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic         clk,
  input  logic         areset_n,
  frame_dump_if.master bus
);
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);
  localparam logic [1:0]    Z_LAST   = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0]    LAT_END  = 2'(READ_LAT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x_q, x_nx;
  logic [YW-1:0] y_q, y_nx;
  logic [1:0]    z_q, z_nx;
  logic [1:0]    lat_q, lat_nx;
  logic [31:0]   word_q, word_nx;
  logic [HW-1:0] hold_q;
  logic          tx_wr_q, tx_wr_nx;
  logic [7:0]    tx_data_q, tx_data_nx;
  logic          gate;
  logic [1:0]    bidx;
  logic [7:0]    cur_byte;

  // Holdoff: the line must have been quiet for HOLDOFF cycles before a write.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      hold_q <= '0;
    end else if (bus.uart_busy || tx_wr_q) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  assign gate     = (hold_q == HOLD_MAX) && !bus.uart_busy && !tx_wr_q;
  assign bidx     = (MSB_FIRST != 0) ? (2'd3 - z_q) : z_q;
  assign cur_byte = word_q[{bidx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      lat_q     <= '0;
      word_q    <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state     <= state_nx;
      x_q       <= x_nx;
      y_q       <= y_nx;
      z_q       <= z_nx;
      lat_q     <= lat_nx;
      word_q    <= word_nx;
      tx_wr_q   <= tx_wr_nx;
      tx_data_q <= tx_data_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    x_nx       = x_q;
    y_nx       = y_q;
    z_nx       = z_q;
    lat_nx     = '0;
    word_nx    = word_q;
    tx_wr_nx   = 1'b0;
    tx_data_nx = tx_data_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          x_nx     = '0;
          y_nx     = '0;
          z_nx     = '0;
          state_nx = (HEADER_EN != 0) ? S_HEADER : S_FETCH;
        end
      end
      S_HEADER: begin
        if (gate) begin
          tx_wr_nx   = 1'b1;
          tx_data_nx = HEADER_BYTE;
          state_nx   = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address has been stable since entry; sample once READ_LAT has elapsed.
        if (lat_q == LAT_END) begin
          word_nx  = bus.rd_data;
          state_nx = S_WAIT;
        end else begin
          lat_nx = lat_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (gate) begin
          tx_wr_nx   = 1'b1;
          tx_data_nx = cur_byte;
          if (z_q != Z_LAST) begin
            z_nx = z_q + 2'd1;
          end else begin
            z_nx = '0;
            if (x_q != X_LAST) begin
              x_nx     = x_q + 1'b1;
              state_nx = S_FETCH;
            end else begin
              x_nx = '0;
              if (y_q != Y_LAST) begin
                y_nx     = y_q + 1'b1;
                state_nx = S_FETCH;
              end else begin
                y_nx     = '0;
                state_nx = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort beats a write gate opening in the same cycle.
    if (bus.abort && (state != S_IDLE)) begin
      state_nx   = S_IDLE;
      tx_wr_nx   = 1'b0;
      tx_data_nx = tx_data_q;
      x_nx       = '0;
      y_nx       = '0;
      z_nx       = '0;
    end
  end

  assign bus.rd_x      = x_q;
  assign bus.rd_y      = y_q;
  assign bus.tx_wr     = tx_wr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_frame_dump_seq.sv
// Bench for frame_dump_seq: two instances (MSB-first with header, and
// LSB-first 2-byte words with a 3-cycle read latency), scoreboarded bytes.
module tb_frame_dump_seq;
  localparam int H = 3;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  frame_dump_if #(.XW(1), .YW(1)) a_if ();
  frame_dump_if #(.XW(1), .YW(1)) b_if ();

  frame_dump_seq #(
    .COLS(2), .ROWS(2), .BYTES_PER_WORD(4), .MSB_FIRST(1), .HOLDOFF(H),
    .READ_LAT(1), .HEADER_EN(1), .HEADER_BYTE(8'hA5)
  ) dut_a (
    .clk(clk), .areset_n(areset_n), .bus(a_if)
  );

  frame_dump_seq #(
    .COLS(2), .ROWS(2), .BYTES_PER_WORD(2), .MSB_FIRST(0), .HOLDOFF(H),
    .READ_LAT(3), .HEADER_EN(0), .HEADER_BYTE(8'hA5)
  ) dut_b (
    .clk(clk), .areset_n(areset_n), .bus(b_if)
  );

  // Instance A buffer: word = {rd_y, rd_x, C3, 3C}, combinational read.
  assign a_if.rd_data = {7'd0, a_if.rd_y, 7'd0, a_if.rd_x, 8'hC3, 8'h3C};

  function automatic logic [31:0] good_b(input logic y, input logic x);
    logic [31:0] idx;
    idx = {30'd0, y, x};
    return 32'h11223344 + (idx << 4);
  endfunction

  // Instance B buffer: junk for 3 cycles after each address change, then data.
  logic [1:0] b_last = 2'b00;
  int         b_age = 7;
  always @(posedge clk) begin
    #1;
    if (b_if.start || ({b_if.rd_y, b_if.rd_x} != b_last)) begin
      b_age  = 0;
      b_last = {b_if.rd_y, b_if.rd_x};
    end else if (b_age < 7) begin
      b_age++;
    end
    b_if.rd_data = (b_age >= 3) ? good_b(b_if.rd_y, b_if.rd_x) : (32'hDEAD0000 | 32'(b_age));
  end

  // Scoreboards
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] exp_byte;
  int a_wr_cnt = 0, a_done_cnt = 0, b_wr_cnt = 0, b_done_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (a_if.tx_wr) begin
      a_wr_cnt++;
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL a_tx_unexpected: got %h, expected no write", a_if.tx_data);
      end else begin
        exp_byte = exp_q_a.pop_front();
        if (a_if.tx_data !== exp_byte) begin
          errors++;
          $display("FAIL a_tx_data #%0d: got %h expected %h", a_wr_cnt, a_if.tx_data, exp_byte);
        end
      end
    end
    if (a_if.done) a_done_cnt++;
    if (b_if.tx_wr) begin
      b_wr_cnt++;
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL b_tx_unexpected: got %h, expected no write", b_if.tx_data);
      end else begin
        exp_byte = exp_q_b.pop_front();
        if (b_if.tx_data !== exp_byte) begin
          errors++;
          $display("FAIL b_tx_data #%0d: got %h expected %h", b_wr_cnt, b_if.tx_data, exp_byte);
        end
      end
    end
    if (b_if.done) b_done_cnt++;
  end

  // Driver tasks
  task automatic push_frame_a();
    exp_q_a.push_back(8'hA5);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        exp_q_a.push_back(8'(y));
        exp_q_a.push_back(8'(x));
        exp_q_a.push_back(8'hC3);
        exp_q_a.push_back(8'h3C);
      end
  endtask

  task automatic pulse_start_a();
    @(negedge clk); a_if.start = 1'b1;
    @(negedge clk); a_if.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); b_if.start = 1'b1;
    @(negedge clk); b_if.start = 1'b0;
  endtask

  task automatic wait_a_wr(input int target, input int budget, output bit ok);
    int n = 0;
    while (a_wr_cnt < target && n < budget) begin @(negedge clk); n++; end
    ok = (a_wr_cnt >= target);
  endtask

  task automatic wait_a_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (a_done_cnt < target && n < budget) begin @(negedge clk); n++; end
    ok = (a_done_cnt >= target);
  endtask

  // Tests
  task automatic test_reset();
    @(negedge clk);
    checks += 6;
    if (a_if.tx_wr !== 1'b0)    begin errors++; $display("FAIL reset_tx_wr: got %b expected 0", a_if.tx_wr); end
    if (a_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", a_if.tx_data); end
    if (a_if.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", a_if.busy); end
    if (a_if.done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", a_if.done); end
    if (a_if.rd_x !== 1'b0)     begin errors++; $display("FAIL reset_rd_x: got %h expected 0", a_if.rd_x); end
    if (a_if.rd_y !== 1'b0)     begin errors++; $display("FAIL reset_rd_y: got %h expected 0", a_if.rd_y); end
    areset_n = 1'b1;
    repeat (H + 4) @(negedge clk);
  endtask

  task automatic test_frame_msb();
    int w0 = a_wr_cnt;
    int d0 = a_done_cnt;
    bit ok;
    push_frame_a();
    pulse_start_a();
    checks++;
    if (a_if.busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b expected 1", a_if.busy); end
    wait_a_wr(w0 + 3, 200, ok);
    pulse_start_a();  // must be ignored mid-dump
    wait_a_done(d0 + 1, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_done_timeout: done count %0d expected %0d", a_done_cnt - d0, 1); end
    repeat (20) @(negedge clk);
    checks += 6;
    if (a_wr_cnt - w0 !== 17)   begin errors++; $display("FAIL frame_write_count: got %0d expected 17", a_wr_cnt - w0); end
    if (a_done_cnt - d0 !== 1)  begin errors++; $display("FAIL frame_done_pulses: got %0d expected 1", a_done_cnt - d0); end
    if (exp_q_a.size() !== 0)   begin errors++; $display("FAIL frame_left_over: got %0d expected 0", exp_q_a.size()); end
    if (a_if.busy !== 1'b0)     begin errors++; $display("FAIL frame_idle_busy: got %b expected 0", a_if.busy); end
    if (a_if.rd_x !== 1'b0)     begin errors++; $display("FAIL frame_end_rd_x: got %h expected 0", a_if.rd_x); end
    if (a_if.rd_y !== 1'b0)     begin errors++; $display("FAIL frame_end_rd_y: got %h expected 0", a_if.rd_y); end
    exp_q_a.delete();
  endtask

  task automatic test_lsb_read_lat();
    int w0 = b_wr_cnt;
    int d0 = b_done_cnt;
    int n = 0;
    logic [31:0] w;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        w = good_b(y[0], x[0]);
        exp_q_b.push_back(w[7:0]);
        exp_q_b.push_back(w[15:8]);
      end
    pulse_start_b();
    while (b_done_cnt == d0 && n < 400) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks += 3;
    if (b_wr_cnt - w0 !== 8)   begin errors++; $display("FAIL lsb_write_count: got %0d expected 8", b_wr_cnt - w0); end
    if (b_done_cnt - d0 !== 1) begin errors++; $display("FAIL lsb_done_pulses: got %0d expected 1", b_done_cnt - d0); end
    if (exp_q_b.size() !== 0)  begin errors++; $display("FAIL lsb_left_over: got %0d expected 0", exp_q_b.size()); end
    exp_q_b.delete();
  endtask

  task automatic test_holdoff();
    int d0 = a_done_cnt;
    int n;
    bit ok;
    push_frame_a();
    pulse_start_a();
    for (int k = 0; k < 17; k++) begin
      n = 0;
      while (!a_if.tx_wr && n < 300) begin @(negedge clk); n++; end
      if (k > 0) begin
        checks++;
        if (!a_if.tx_wr || n < H + 1 || n > H + 3) begin
          errors++;
          $display("FAIL holdoff_gap write %0d: got %0d cycles expected %0d..%0d", k, n, H + 1, H + 3);
        end
      end
      @(negedge clk); a_if.uart_busy = 1'b1;
      repeat (99) @(negedge clk);
      a_if.uart_busy = 1'b0;
    end
    wait_a_done(d0 + 1, 50, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL holdoff_done: got %0d pulses expected 1", a_done_cnt - d0); end
    if (exp_q_a.size() !== 0) begin errors++; $display("FAIL holdoff_left_over: got %0d expected 0", exp_q_a.size()); end
    exp_q_a.delete();
    repeat (H + 2) @(negedge clk);
  endtask

  task automatic test_abort();
    int w0 = a_wr_cnt;
    int d0 = a_done_cnt;
    bit ok;
    push_frame_a();
    pulse_start_a();
    wait_a_wr(w0 + 5, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach5: got %0d writes expected 5", a_wr_cnt - w0); end
    a_if.abort = 1'b1;
    exp_q_a.delete();
    @(negedge clk);
    a_if.abort = 1'b0;
    checks += 2;
    if (a_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", a_if.busy); end
    if (a_if.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", a_if.done); end
    repeat (40) @(negedge clk);
    checks += 2;
    if (a_wr_cnt - w0 !== 5)  begin errors++; $display("FAIL abort_writes: got %0d expected 5", a_wr_cnt - w0); end
    if (a_done_cnt !== d0)    begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", a_done_cnt, d0); end
  endtask

  task automatic test_async_reset();
    int w0 = a_wr_cnt;
    bit ok;
    push_frame_a();
    pulse_start_a();
    wait_a_wr(w0 + 8, 300, ok);  // now in WAIT at rd_x=1 with C3 on tx_data
    checks++;
    if (!ok) begin errors++; $display("FAIL areset_reach8: got %0d writes expected 8", a_wr_cnt - w0); end
    @(posedge clk);
    #3 areset_n = 1'b0;
    exp_q_a.delete();
    #1;
    checks += 6;
    if (a_if.tx_wr !== 1'b0)    begin errors++; $display("FAIL areset_tx_wr: got %b expected 0", a_if.tx_wr); end
    if (a_if.tx_data !== 8'h00) begin errors++; $display("FAIL areset_tx_data: got %h expected 00", a_if.tx_data); end
    if (a_if.busy !== 1'b0)     begin errors++; $display("FAIL areset_busy: got %b expected 0", a_if.busy); end
    if (a_if.done !== 1'b0)     begin errors++; $display("FAIL areset_done: got %b expected 0", a_if.done); end
    if (a_if.rd_x !== 1'b0)     begin errors++; $display("FAIL areset_rd_x: got %h expected 0", a_if.rd_x); end
    if (a_if.rd_y !== 1'b0)     begin errors++; $display("FAIL areset_rd_y: got %h expected 0", a_if.rd_y); end
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks += 2;
    if (a_wr_cnt - w0 !== 8) begin errors++; $display("FAIL areset_no_tx: got %0d writes expected 8", a_wr_cnt - w0); end
    if (a_if.busy !== 1'b0)  begin errors++; $display("FAIL areset_idle: got busy %b expected 0", a_if.busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.uart_busy = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.uart_busy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame_msb();
    test_lsb_read_lat();
    test_holdoff();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
